// File: rtl/note_scheduler.sv
// Song sequencer: walks the beat chart against a frame counter, hands each note to the
// lowest free dropper slot and keeps score / combo / miss tallies from slot feedback.
module note_scheduler #(
  parameter int N_SLOTS = 16,
  parameter int T_W     = 12,
  parameter int ADDR_W  = 8,
  parameter int HIT_PTS = 10
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [7:0]         keycode_second,
  output logic [ADDR_W-1:0]  chart_addr,
  input  logic [T_W-1:0]     chart_time,
  input  logic [1:0]         chart_lane,
  input  logic               chart_last,
  input  logic [N_SLOTS-1:0] slot_busy,
  input  logic [N_SLOTS-1:0] slot_hit,
  input  logic [N_SLOTS-1:0] slot_miss,
  output logic [N_SLOTS-1:0] slot_spawn,
  output logic [1:0]         spawn_lane,
  output logic               slot_clear,
  output logic [15:0]        score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [7:0]         miss_cnt,
  output logic               song_done,
  output logic [2:0]         state_o
);

  localparam int CNT_W = $clog2(N_SLOTS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SPAWN = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [T_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [ADDR_W-1:0]   chart_addr_q, chart_addr_d;
  logic [T_W-1:0]      entry_time_q, entry_time_d;
  logic [1:0]          entry_lane_q, entry_lane_d;
  logic                entry_last_q, entry_last_d;
  logic [15:0]         score_q, score_d;
  logic [7:0]          combo_q, combo_d;
  logic [7:0]          max_combo_q, max_combo_d;
  logic [7:0]          miss_q, miss_d;

  logic                start_key, abort_key, spawning, found, drop;
  logic [N_SLOTS-1:0]  free_oh;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W:0]      miss_tot;
  logic [31:0]         score_sum, combo_sum, miss_sum;

  assign start_key = (keycode == 8'h2C) || (keycode_second == 8'h2C);
  assign abort_key = (keycode == 8'h01);

  // Lowest-index idle slot, plus hit/miss population counts for this cycle.
  always_comb begin
    free_oh = '0;
    found   = 1'b0;
    hit_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!slot_busy[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
      hit_cnt = hit_cnt + CNT_W'(slot_hit[i]);
    end
  end

  assign spawning   = (state_q == S_SPAWN) && !abort_key;
  assign drop       = spawning && !found;
  assign slot_spawn = spawning ? free_oh : '0;
  assign spawn_lane = (spawning && found) ? entry_lane_q : 2'd0;
  assign slot_clear = abort_key && (state_q inside {S_FETCH, S_WAIT, S_SPAWN, S_DRAIN});

  always_comb begin
    miss_tot = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      miss_tot = miss_tot + (CNT_W + 1)'(slot_miss[i]);
    end
    miss_tot = miss_tot + (CNT_W + 1)'(drop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_key) state_d = S_FETCH;
      S_FETCH: state_d = abort_key ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort_key)                         state_d = S_IDLE;
        else if (frame_cnt_q >= entry_time_q)  state_d = S_SPAWN;
      end
      S_SPAWN: begin
        if (abort_key)         state_d = S_IDLE;
        else if (entry_last_q) state_d = S_DRAIN;
        else                   state_d = S_FETCH;
      end
      S_DRAIN: begin
        if (abort_key)            state_d = S_IDLE;
        else if (slot_busy == '0) state_d = S_DONE;
      end
      S_DONE:  if (abort_key) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame counter and chart pointer are pinned to zero whenever IDLE is current or next.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    chart_addr_d = chart_addr_q;
    entry_time_d = entry_time_q;
    entry_lane_d = entry_lane_q;
    entry_last_d = entry_last_q;
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      frame_cnt_d  = '0;
      chart_addr_d = '0;
    end else begin
      if (state_q != S_DONE && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + T_W'(1);
      if (state_q == S_SPAWN && state_d == S_FETCH) chart_addr_d = chart_addr_q + ADDR_W'(1);
      if (state_q == S_FETCH) begin
        entry_time_d = chart_time;
        entry_lane_d = chart_lane;
        entry_last_d = chart_last;
      end
    end
  end

  always_comb begin
    score_sum   = 32'(score_q) + 32'(HIT_PTS) * 32'(hit_cnt);
    combo_sum   = 32'(combo_q) + 32'(hit_cnt);
    miss_sum    = 32'(miss_q) + 32'(miss_tot);
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    miss_d      = miss_q;
    if (state_q == S_IDLE) begin
      if (start_key) begin
        score_d     = '0;
        combo_d     = '0;
        max_combo_d = '0;
        miss_d      = '0;
      end
    end else begin
      score_d     = (score_sum > 32'hFFFF) ? 16'hFFFF : score_sum[15:0];
      combo_d     = (miss_tot != '0) ? 8'd0 : ((combo_sum > 32'd255) ? 8'hFF : combo_sum[7:0]);
      max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
      miss_d      = (miss_sum > 32'd255) ? 8'hFF : miss_sum[7:0];
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= '0;
      chart_addr_q <= '0;
      entry_time_q <= '0;
      entry_lane_q <= '0;
      entry_last_q <= 1'b0;
      score_q      <= '0;
      combo_q      <= '0;
      max_combo_q  <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      chart_addr_q <= chart_addr_d;
      entry_time_q <= entry_time_d;
      entry_lane_q <= entry_lane_d;
      entry_last_q <= entry_last_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      max_combo_q  <= max_combo_d;
      miss_q       <= miss_d;
    end
  end

  assign chart_addr = chart_addr_q;
  assign score      = score_q;
  assign combo      = combo_q;
  assign max_combo  = max_combo_q;
  assign miss_cnt   = miss_q;
  assign song_done  = (state_q == S_DONE);
  assign state_o    = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: chart playback, scoring, drops, abort, async reset, saturation.
module tb_note_scheduler;
  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode, keycode_second;
  logic [7:0]  chart_addr;
  logic [11:0] chart_time;
  logic [1:0]  chart_lane;
  logic        chart_last;
  logic [15:0] slot_busy, slot_hit, slot_miss, slot_spawn;
  logic [1:0]  spawn_lane;
  logic        slot_clear, song_done;
  logic [15:0] score;
  logic [7:0]  combo, max_combo, miss_cnt;
  logic [2:0]  state_o;

  logic [11:0] rom_time [256];
  logic [1:0]  rom_lane [256];
  logic        rom_last [256];

  int n_checks = 0;
  int n_fail   = 0;

  assign chart_time = rom_time[chart_addr];
  assign chart_lane = rom_lane[chart_addr];
  assign chart_last = rom_last[chart_addr];

  always #5 frame_clk = ~frame_clk;

  note_scheduler dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
    .chart_addr(chart_addr), .chart_time(chart_time), .chart_lane(chart_lane), .chart_last(chart_last),
    .slot_busy(slot_busy), .slot_hit(slot_hit), .slot_miss(slot_miss), .slot_spawn(slot_spawn),
    .spawn_lane(spawn_lane), .slot_clear(slot_clear), .score(score), .combo(combo),
    .max_combo(max_combo), .miss_cnt(miss_cnt), .song_done(song_done), .state_o(state_o)
  );

  task automatic tick();
    @(posedge frame_clk);
    #2;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom_time[i] = 12'hFFF;
      rom_lane[i] = 2'd0;
      rom_last[i] = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; keycode = 8'h00; keycode_second = 8'h00;
    slot_busy = '0; slot_hit = '0; slot_miss = '0;
    clear_rom();
    #3;
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_checks++; if (chart_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", chart_addr); end
    n_checks++; if ({score, combo, max_combo, miss_cnt} !== 40'd0) begin n_fail++; $display("FAIL reset_counters: got %0h want 0", {score, combo, max_combo, miss_cnt}); end
    n_checks++; if ({slot_spawn, slot_clear, song_done} !== 18'd0) begin n_fail++; $display("FAIL reset_pulses: got %0h want 0", {slot_spawn, slot_clear, song_done}); end
    tick(); tick();
    Reset = 1'b1;
    tick();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", state_o); end
  endtask

  // FETCH sits at frame 0; WAIT sees the frame count one higher each cycle, SPAWN follows the
  // first WAIT cycle with frame >= time, so entries t=5,5,20 spawn at frames 6, 9 and 21.
  task automatic test_chart_play();
    int exp_cyc [3] = '{6, 9, 21};
    logic [15:0] exp_oh [3] = '{16'h0001, 16'h0002, 16'h0004};
    logic [1:0]  exp_ln [3] = '{2'd0, 2'd1, 2'd2};
    logic [15:0] busy_m = '0;
    logic [15:0] pend;
    int k = 0;
    clear_rom();
    rom_time[0] = 12'd5;  rom_lane[0] = 2'd0; rom_last[0] = 1'b0;
    rom_time[1] = 12'd5;  rom_lane[1] = 2'd1; rom_last[1] = 1'b0;
    rom_time[2] = 12'd20; rom_lane[2] = 2'd2; rom_last[2] = 1'b1;
    keycode = 8'h2C; tick(); keycode = 8'h00;
    n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL start_fetch: got %0d want 1", state_o); end
    for (int c = 0; c < 23; c++) begin
      slot_busy = busy_m;
      #1;
      pend = slot_spawn;
      if (slot_spawn != '0) begin
        if (k < 3) begin
          n_checks++;
          if (c !== exp_cyc[k] || slot_spawn !== exp_oh[k] || spawn_lane !== exp_ln[k]) begin
            n_fail++;
            $display("FAIL spawn%0d: got cyc %0d oh %0h lane %0d want cyc %0d oh %0h lane %0d",
                     k, c, slot_spawn, spawn_lane, exp_cyc[k], exp_oh[k], exp_ln[k]);
          end
        end
        k++;
      end
      tick();
      busy_m = busy_m | pend;
    end
    n_checks++; if (k !== 3) begin n_fail++; $display("FAIL spawn_count: got %0d want 3", k); end
    slot_busy = busy_m; #1;
    n_checks++; if (state_o !== 3'd4 || song_done !== 1'b0) begin n_fail++; $display("FAIL drain: got state %0d done %0b want 4 0", state_o, song_done); end
    tick();
    slot_busy = '0;
    tick();
    n_checks++; if (state_o !== 3'd5 || song_done !== 1'b1) begin n_fail++; $display("FAIL done: got state %0d done %0b want 5 1", state_o, song_done); end
    keycode = 8'h01; tick(); keycode = 8'h00;
    n_checks++; if (state_o !== 3'd0 || song_done !== 1'b0) begin n_fail++; $display("FAIL done_exit: got state %0d done %0b want 0 0", state_o, song_done); end
  endtask

  task automatic test_hit_combo();
    clear_rom();
    rom_time[0] = 12'd4000;
    keycode_second = 8'h2C; tick(); keycode_second = 8'h00;
    for (int i = 0; i < 9; i++) begin
      slot_hit = 16'h0001; tick();
    end
    slot_hit = '0;
    n_checks++; if (combo !== 8'd9 || score !== 16'd90) begin n_fail++; $display("FAIL combo9: got combo %0d score %0d want 9 90", combo, score); end
    slot_hit = 16'h0003; tick(); slot_hit = '0;
    n_checks++; if (score !== 16'd110) begin n_fail++; $display("FAIL double_hit_score: got %0d want 110", score); end
    n_checks++; if (combo !== 8'd11 || max_combo !== 8'd11) begin n_fail++; $display("FAIL double_hit_combo: got %0d/%0d want 11/11", combo, max_combo); end
    slot_hit = 16'h0001; slot_miss = 16'h0006; tick(); slot_hit = '0; slot_miss = '0;
    n_checks++; if (score !== 16'd120 || combo !== 8'd0) begin n_fail++; $display("FAIL hit_miss: got score %0d combo %0d want 120 0", score, combo); end
    n_checks++; if (miss_cnt !== 8'd2 || max_combo !== 8'd11) begin n_fail++; $display("FAIL hit_miss_cnt: got miss %0d max %0d want 2 11", miss_cnt, max_combo); end
  endtask

  task automatic test_no_free_slot();
    keycode = 8'h01; tick(); keycode = 8'h00;
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL abort_idle: got %0d want 0", state_o); end
    clear_rom();
    rom_time[0] = 12'd0;    rom_lane[0] = 2'd3; rom_last[0] = 1'b0;
    rom_time[1] = 12'd4000; rom_lane[1] = 2'd0; rom_last[1] = 1'b1;
    keycode = 8'h2C; tick(); keycode = 8'h00;
    slot_busy = 16'hFFFF; slot_hit = 16'h0003; tick(); slot_hit = '0;
    tick();
    #1;
    n_checks++; if (state_o !== 3'd3 || slot_spawn !== 16'h0) begin n_fail++; $display("FAIL full_spawn: got state %0d spawn %0h want 3 0", state_o, slot_spawn); end
    n_checks++; if (chart_addr !== 8'd0) begin n_fail++; $display("FAIL full_addr0: got %0d want 0", chart_addr); end
    tick();
    n_checks++; if (state_o !== 3'd1 || chart_addr !== 8'd1) begin n_fail++; $display("FAIL drop_advance: got state %0d addr %0d want 1 1", state_o, chart_addr); end
    n_checks++; if (miss_cnt !== 8'd1 || combo !== 8'd0) begin n_fail++; $display("FAIL drop_count: got miss %0d combo %0d want 1 0", miss_cnt, combo); end
    n_checks++; if (score !== 16'd20 || max_combo !== 8'd2) begin n_fail++; $display("FAIL drop_score: got score %0d max %0d want 20 2", score, max_combo); end
  endtask

  task automatic test_abort();
    slot_busy = 16'h000F; tick();
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL abort_wait: got %0d want 2", state_o); end
    keycode = 8'h01; #1;
    n_checks++; if (slot_clear !== 1'b1 || slot_spawn !== 16'h0) begin n_fail++; $display("FAIL abort_clear: got clear %0b spawn %0h want 1 0", slot_clear, slot_spawn); end
    tick();
    n_checks++; if (state_o !== 3'd0 || slot_clear !== 1'b0) begin n_fail++; $display("FAIL abort_pulse: got state %0d clear %0b want 0 0", state_o, slot_clear); end
    keycode = 8'h2C; tick(); keycode = 8'h00;
    n_checks++; if (state_o !== 3'd1 || chart_addr !== 8'd0) begin n_fail++; $display("FAIL restart: got state %0d addr %0d want 1 0", state_o, chart_addr); end
    n_checks++; if (score !== 16'd0 || miss_cnt !== 8'd0 || max_combo !== 8'd0) begin n_fail++; $display("FAIL restart_clear: got %0d/%0d/%0d want 0/0/0", score, miss_cnt, max_combo); end
  endtask

  task automatic test_reset_in_spawn();
    slot_busy = '0; slot_hit = 16'h0001; tick(); slot_hit = '0;
    tick();
    n_checks++; if (state_o !== 3'd3 || score !== 16'd10) begin n_fail++; $display("FAIL pre_reset: got state %0d score %0d want 3 10", state_o, score); end
    Reset = 1'b0; #1;
    n_checks++; if (state_o !== 3'd0 || slot_spawn !== 16'h0 || spawn_lane !== 2'd0) begin n_fail++; $display("FAIL async_reset: got state %0d spawn %0h lane %0d want 0 0 0", state_o, slot_spawn, spawn_lane); end
    n_checks++; if (score !== 16'd0 || chart_addr !== 8'd0 || slot_clear !== 1'b0) begin n_fail++; $display("FAIL async_reset_regs: got score %0d addr %0d clear %0b want 0 0 0", score, chart_addr, slot_clear); end
    tick(); tick();
    Reset = 1'b1;
    tick();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL post_reset: got %0d want 0", state_o); end
  endtask

  task automatic test_saturation();
    clear_rom();
    rom_time[0] = 12'hFFF;
    keycode = 8'h2C; tick(); keycode = 8'h00;
    for (int i = 0; i < 300; i++) begin
      slot_hit = 16'h0001; tick();
    end
    slot_hit = '0;
    n_checks++; if (combo !== 8'd255 || max_combo !== 8'd255) begin n_fail++; $display("FAIL combo_sat: got %0d/%0d want 255/255", combo, max_combo); end
    n_checks++; if (score !== 16'd3000) begin n_fail++; $display("FAIL score3000: got %0d want 3000", score); end
    for (int i = 0; i < 419; i++) begin
      slot_hit = 16'hFFFF; tick();
    end
    n_checks++; if (score !== 16'hFFFF) begin n_fail++; $display("FAIL score_sat: got %0h want ffff", score); end
    tick(); slot_hit = '0;
    n_checks++; if (score !== 16'hFFFF || combo !== 8'd255) begin n_fail++; $display("FAIL score_hold: got %0h combo %0d want ffff 255", score, combo); end
    n_checks++; if (miss_cnt !== 8'd0 || state_o !== 3'd2) begin n_fail++; $display("FAIL sat_state: got miss %0d state %0d want 0 2", miss_cnt, state_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_chart_play();
    test_hit_combo();
    test_no_free_slot();
    test_abort();
    test_reset_in_spawn();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
